// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared alu32: grants one operation at a time,
// registers the ALU drive, captures the result and holds it on the winner's response channel.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_ovf,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_ovf,

  output logic             busy,
  output logic             owner,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Requesters hold valid and payload stable until that edge; ready may depend on valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q;
  logic   owner_q;
  logic   grant;
  logic   accept;
  logic   rsp_done;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
  end

  always_comb begin
    req0_ready = (state_q == S_IDLE) && req0_valid && !grant;
    req1_ready = (state_q == S_IDLE) && req1_valid &&  grant;
    accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);
    rsp_done   = (state_q == S_RESP) && (owner_q ? rsp1_ready : rsp0_ready);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)   state_d = S_EXEC;
      S_EXEC:                state_d = S_RESP;
      S_RESP:  if (rsp_done) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= 3'b000;
      rsp_data <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= grant;
        last_q  <= grant;
        alu_a   <= grant ? req1_a   : req0_a;
        alu_b   <= grant ? req1_b   : req0_b;
        alu_sel <= grant ? req1_sel : req0_sel;
      end
      // The ALU has had the whole EXEC cycle to settle from the registered drive.
      if (state_q == S_EXEC) begin
        rsp_data <= alu_out;
        rsp_cout <= alu_cout;
        rsp_ovf  <= alu_ovf;
      end
    end
  end

  always_comb begin
    rsp0_valid = (state_q == S_RESP) && !owner_q;
    rsp1_valid = (state_q == S_RESP) &&  owner_q;
    busy       = (state_q != S_IDLE);
    owner      = owner_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural alu32 stand-in, directed scenarios and a randomized
// two-requester run scored against per-requester expected queues.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_sel, req1_sel;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_cout, rsp_ovf;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_sel;
  logic         alu_cout, alu_ovf;
  logic         busy, owner;
  logic [1:0]   dbg_state;
  logic [33:0]  alu_res;

  int n_checks = 0;
  int n_errors = 0;
  bit mlast;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // Returns {cout, ovf, data}
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    logic [32:0] s;
    logic [31:0] d;
    logic        c, v;
    c = 1'b0; v = 1'b0; s = '0; d = '0;
    case (sel)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        d = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (d[31] != a[31]);
      end
      3'd3: d = a ^ b;
      3'd4: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        d = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (d[31] != a[31]);
      end
      3'd5: d = $signed(a) >>> b[4:0];
      3'd6: d = a << b[4:0];
      default: d = ~(a | b);
    endcase
    return {c, v, d};
  endfunction

  assign alu_res = alu_ref(alu_a, alu_b, alu_sel);
  assign {alu_cout, alu_ovf, alu_out} = alu_res;

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = '0; req0_b = '0; req0_sel = '0; req1_a = '0; req1_b = '0; req1_sel = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    mlast = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input bit n, input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel, output bit ok);
    ok = 0;
    if (!n) begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1; end
    else    begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1; end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if ((!n && req0_ready) || (n && req1_ready)) ok = 1;
      @(negedge clk);
    end
    if (!n) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_rsp(input bit n, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if ((!n && rsp0_valid) || (n && rsp1_valid)) ok = 1;
      else @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ok;
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_errors++; $display("FAIL reset_rsp_valid: got %b exp 00", {rsp0_valid, rsp1_valid}); end
    n_checks++; if ({alu_a, alu_b, alu_sel} !== 67'd0) begin n_errors++; $display("FAIL reset_alu_regs: got %h %h %b exp zeros", alu_a, alu_b, alu_sel); end
    n_checks++; if ({rsp_data, rsp_cout, rsp_ovf} !== 34'd0) begin n_errors++; $display("FAIL reset_rsp_regs: got %h %b %b exp zeros", rsp_data, rsp_cout, rsp_ovf); end
    n_checks++; if (owner !== 1'b0) begin n_errors++; $display("FAIL reset_owner: got %b exp 0", owner); end

    // Reset while a response is being held
    rsp0_ready = 0;
    send(0, 32'h0000_F0F0, 32'h00FF_00FF, 3'd3, ok);
    wait_rsp(0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rstmid_reach_resp: got %b exp 1", ok); end
    rst_n = 0;
    #1;
    n_checks++; if (rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_rsp0_valid: got %b exp 0", rsp0_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1; mlast = 1'b1;
    @(negedge clk);
    n_checks++; if (alu_sel !== 3'b000) begin n_errors++; $display("FAIL rstmid_alu_sel: got %b exp 000", alu_sel); end
    n_checks++; if (rsp_data !== 32'h0) begin n_errors++; $display("FAIL rstmid_rsp_data: got %h exp 0", rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy_after: got %b exp 0", busy); end
  endtask

  task automatic test_single_add();
    bit ok;
    do_reset();
    rsp0_ready = 1;
    send(0, 32'hC000_00EA, 32'hF1E0_0000, 3'd2, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL add_accept: got %b exp 1", ok); end
    n_checks++; if ({busy, rsp0_valid} !== 2'b10) begin n_errors++; $display("FAIL add_exec: busy/valid got %b exp 10", {busy, rsp0_valid}); end
    @(negedge clk);
    n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_errors++; $display("FAIL add_rsp_valid: got %b exp 10", {rsp0_valid, rsp1_valid}); end
    n_checks++; if (rsp_data !== 32'hB1E0_00EA) begin n_errors++; $display("FAIL add_data: got %h exp b1e000ea", rsp_data); end
    n_checks++; if ({rsp_cout, rsp_ovf} !== 2'b10) begin n_errors++; $display("FAIL add_flags: got %b exp 10", {rsp_cout, rsp_ovf}); end
    @(negedge clk);
    n_checks++; if ({busy, rsp0_valid} !== 2'b00) begin n_errors++; $display("FAIL add_done: busy/valid got %b exp 00", {busy, rsp0_valid}); end
    rsp0_ready = 0;
  endtask

  task automatic test_tie_alternation();
    int got, cyc, prev;
    bit exp_n;
    logic [31:0] exp_d;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_a = 32'hC000_0000; req0_b = 32'hC000_001F; req0_sel = 3'd0; req0_valid = 1;
    req1_a = 32'hC000_00FF; req1_b = 32'h0000_0003; req1_sel = 3'd6; req1_valid = 1;
    got = 0; cyc = 0; prev = 0;
    while (got < 4 && cyc < 60) begin
      if (rsp0_valid || rsp1_valid) begin
        exp_n = ~mlast; mlast = exp_n;
        exp_d = exp_n ? 32'h0000_07F8 : 32'hC000_0000;
        n_checks++; if ({rsp0_valid, rsp1_valid} !== {~exp_n, exp_n}) begin n_errors++; $display("FAIL tie_order[%0d]: rsp0/rsp1 got %b exp %b", got, {rsp0_valid, rsp1_valid}, {~exp_n, exp_n}); end
        n_checks++; if (rsp_data !== exp_d) begin n_errors++; $display("FAIL tie_data[%0d]: got %h exp %h", got, rsp_data, exp_d); end
        if (got > 0) begin
          n_checks++; if (cyc - prev != 3) begin n_errors++; $display("FAIL tie_spacing[%0d]: got %0d exp 3", got, cyc - prev); end
        end
        prev = cyc; got++;
      end
      @(negedge clk); cyc++;
    end
    req0_valid = 0; req1_valid = 0;
    n_checks++; if (got != 4) begin n_errors++; $display("FAIL tie_count: got %0d exp 4", got); end
    repeat (3) @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_back_pressure();
    bit ok;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 0;
    send(1, 32'hC000_00FF, 32'h0000_0003, 3'd5, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL bp_accept: got %b exp 1", ok); end
    req0_a = 32'd1; req0_b = 32'd2; req0_sel = 3'd2; req0_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({rsp1_valid, rsp_data} !== {1'b1, 32'hF800_001F}) begin n_errors++; $display("FAIL bp_hold[%0d]: valid/data got %b %h exp 1 f800001f", i, rsp1_valid, rsp_data); end
      n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL bp_req0_ready[%0d]: got %b exp 0", i, req0_ready); end
      @(negedge clk);
    end
    rsp1_ready = 1;
    #1;
    n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL bp_no_overlap: req0_ready got %b exp 0", req0_ready); end
    @(negedge clk);
    rsp1_ready = 0;
    n_checks++; if ({busy, rsp1_valid, req0_ready} !== 3'b001) begin n_errors++; $display("FAIL bp_idle: busy/rsp1_valid/req0_ready got %b exp 001", {busy, rsp1_valid, req0_ready}); end
    @(negedge clk);
    req0_valid = 0;
    n_checks++; if ({busy, owner} !== 2'b10) begin n_errors++; $display("FAIL bp_next_grant: busy/owner got %b exp 10", {busy, owner}); end
    @(negedge clk);
    n_checks++; if ({rsp0_valid, rsp_data} !== {1'b1, 32'd3}) begin n_errors++; $display("FAIL bp_next_rsp: got %b %h exp 1 00000003", rsp0_valid, rsp_data); end
    @(negedge clk);
    rsp0_ready = 0;
  endtask

  task automatic test_sub_ovf();
    bit ok;
    rsp0_ready = 1;
    send(0, 32'hFF00_00FF, 32'h71E0_003E, 3'd4, ok);
    wait_rsp(0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL sub_rsp: got %b exp 1", ok); end
    n_checks++; if ({rsp_data, rsp_ovf} !== {32'h8D20_00C1, 1'b0}) begin n_errors++; $display("FAIL sub_data: got %h ovf %b exp 8d2000c1 ovf 0", rsp_data, rsp_ovf); end
    @(negedge clk);
    send(0, 32'h7FFF_FFFF, 32'h0000_0001, 3'd2, ok);
    wait_rsp(0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL addovf_rsp: got %b exp 1", ok); end
    n_checks++; if ({rsp_data, rsp_cout, rsp_ovf} !== {32'h8000_0000, 2'b01}) begin n_errors++; $display("FAIL addovf_data: got %h c%b v%b exp 80000000 c0 v1", rsp_data, rsp_cout, rsp_ovf); end
    @(negedge clk);
    rsp0_ready = 0;
  endtask

  task automatic test_wrong_owner();
    bit ok;
    rsp0_ready = 0;
    send(0, 32'h1234_5678, 32'h0F0F_0F0F, 3'd3, ok);
    wait_rsp(0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL wo_rsp: got %b exp 1", ok); end
    rsp1_ready = 1;
    @(negedge clk);
    n_checks++; if (dbg_state !== 2'd2) begin n_errors++; $display("FAIL wo_state: got %0d exp 2", dbg_state); end
    n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_errors++; $display("FAIL wo_valids: got %b exp 10", {rsp0_valid, rsp1_valid}); end
    n_checks++; if (rsp_data !== 32'h1D3B_5977) begin n_errors++; $display("FAIL wo_data: got %h exp 1d3b5977", rsp_data); end
    rsp1_ready = 0; rsp0_ready = 1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wo_release: busy got %b exp 0", busy); end
    rsp0_ready = 0;
  endtask

  task automatic test_random();
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];
    int  left0, left1, cyc;
    bit  pend0, pend1, win;
    do_reset();
    left0 = 40; left1 = 40; pend0 = 0; pend1 = 0; cyc = 0;
    while ((left0 > 0 || left1 > 0 || pend0 || pend1 || exp_q0.size() > 0 || exp_q1.size() > 0) && cyc < 4000) begin
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if (!pend0) begin
        if (left0 > 0 && $urandom_range(0, 1) == 1) begin
          req0_a = rand_opnd(); req0_b = rand_opnd(); req0_sel = 3'($urandom_range(0, 7));
          req0_valid = 1; pend0 = 1; left0--;
        end else req0_valid = 0;
      end
      if (!pend1) begin
        if (left1 > 0 && $urandom_range(0, 1) == 1) begin
          req1_a = rand_opnd(); req1_b = rand_opnd(); req1_sel = 3'($urandom_range(0, 7));
          req1_valid = 1; pend1 = 1; left1--;
        end else req1_valid = 0;
      end
      #1;
      if (rsp0_valid) begin
        n_checks++;
        if (exp_q0.size() == 0) begin n_errors++; $display("FAIL rnd_rsp0_unexpected: data %h with empty queue", rsp_data); end
        else begin
          if ({rsp_cout, rsp_ovf, rsp_data} !== exp_q0[0]) begin n_errors++; $display("FAIL rnd_rsp0: got %h exp %h", {rsp_cout, rsp_ovf, rsp_data}, exp_q0[0]); end
          if (rsp0_ready) void'(exp_q0.pop_front());
        end
      end
      if (rsp1_valid) begin
        n_checks++;
        if (exp_q1.size() == 0) begin n_errors++; $display("FAIL rnd_rsp1_unexpected: data %h with empty queue", rsp_data); end
        else begin
          if ({rsp_cout, rsp_ovf, rsp_data} !== exp_q1[0]) begin n_errors++; $display("FAIL rnd_rsp1: got %h exp %h", {rsp_cout, rsp_ovf, rsp_data}, exp_q1[0]); end
          if (rsp1_ready) void'(exp_q1.pop_front());
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        win = req1_valid && req1_ready;
        n_checks++; if (req0_ready && req1_ready) begin n_errors++; $display("FAIL rnd_double_grant: ready got 11 exp one-hot"); end
        if (req0_valid && req1_valid) begin
          n_checks++; if (win !== ~mlast) begin n_errors++; $display("FAIL rnd_fairness: granted %0d exp %0d", win, ~mlast); end
        end
        mlast = win;
        if (win) begin exp_q1.push_back(alu_ref(req1_a, req1_b, req1_sel)); pend1 = 0; end
        else     begin exp_q0.push_back(alu_ref(req0_a, req0_b, req0_sel)); pend0 = 0; end
      end
      @(negedge clk); cyc++;
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    n_checks++; if (cyc >= 4000) begin n_errors++; $display("FAIL rnd_timeout: %0d cycles, left %0d/%0d", cyc, left0, left1); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    test_reset();
    test_single_add();
    test_tie_alternation();
    test_back_pressure();
    test_sub_ovf();
    test_wrong_owner();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares a single `alu32` instance between two requesters, such as the main datapath and a debug/self-test port. Each requester presents operands and a 3-bit ALU select with a valid/ready handshake. The block registers the winning operation, drives the ALU for one cycle, and captures the result, carry and overflow. It then holds them on the winner's response channel until accepted. It sits between the requesters and an external `alu32`, which is instantiated alongside it.

## Interface

- `WIDTH`, 32: operand/result width; must match `alu32`.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle when valid & ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in WIDTH: operands.
- `req0_sel` / `req1_sel` in 3: ALU select.
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SUB, 101 SRA (A by B[4:0]), 110 SLL, 111 NOR.
- `rsp0_valid` / `rsp1_valid` out 1: result held for that requester.
- `rsp0_ready` / `rsp1_ready` in 1: requester consumes result.
- `rsp_data` out WIDTH, `rsp_cout` out 1, `rsp_ovf` out 1: shared response payload, meaningful only while a `rspN_valid` is high.
- `alu_a`, `alu_b` out WIDTH, `alu_sel` out 3: registered drive to `alu32`.
- `alu_out` in WIDTH, `alu_cout` in 1, `alu_ovf` in 1: `alu32` outputs.
- `busy` out 1: high in EXEC or RESP.
- `owner` out 1: requester currently owning the ALU; valid while `busy`.

## Operation

- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant is combinational:
    - If exactly one `reqN_valid` is high, grant that requester.
    - If both are high, grant the requester that is not `last`.
  - `reqN_ready` = (state==IDLE) & grant==N. Ready may depend on valid; requesters must not make valid depend on ready.
  - On accept: capture a/b/sel into the `alu_*` registers, set `owner`=N and `last`=N, go to EXEC.
- **EXEC** (exactly 1 cycle)
  - The ALU settles combinationally from the registered inputs.
  - At the end of the cycle, capture `alu_out`/`alu_cout`/`alu_ovf` into the `rsp_*` registers and go to RESP.
- **RESP**
  - `rsp<owner>_valid`=1; the other `rspN_valid`=0.
  - Payload is stable until the handshake.
  - When `rsp<owner>_ready`=1, go to IDLE.
  - `rspN_ready` on the non-owner is ignored.
- Requests arriving while busy wait. Valid must be held stable until accepted; the block never drops or reorders a held request.
- Selects pass through unmodified; all 8 codes are legal. No width conversion; `cout`/`ovf` semantics are those of `alu32`.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Timing

- **Reset** (async assert, sync release), all values below:
  - state=IDLE, `last`=1 (requester 0 wins the first tie), `owner`=0.
  - `alu_a`=`alu_b`=0, `alu_sel`=000.
  - `rsp_data`=0, `rsp_cout`=0, `rsp_ovf`=0.
  - `rsp0_valid`=`rsp1_valid`=0, `busy`=0.
  - `req*_ready`=0 is not guaranteed by reset: in IDLE it follows the grant logic.
- **Latency**
  - Accept at edge E0, result captured at E0+1, `rspN_valid` high from E0+1.
  - If `rspN_ready` is already high, the response completes at E0+2.
  - Next accept is possible no earlier than edge E0+3.
  - Peak throughput is one operation per 3 cycles.
- **Back-pressure:** `rspN_ready` held low keeps RESP indefinitely, with payload unchanged.
- **Reset mid-operation:** the in-flight operation is discarded. `rsp*_valid` drop immediately on `rst_n` low, with no partial response.
- **Simultaneous events:** a response handshake and new requests in the same cycle do not overlap. A new grant is evaluated only in the cycle after return to IDLE, using the updated `last`.

## Test plan

- **Reset:** `rst_n`=0 mid-RESP → `rsp0_valid`=0 immediately; after release, `busy`=0, `alu_sel`=000.
- **Single ADD:** req0 A=0xC00000EA, B=0xF1E00000, sel=010, `rsp0_ready`=1 → `rsp0_valid` one edge after accept, `rsp_data`=0xB1E000EA, `rsp_cout`=1, `rsp_ovf`=0, `busy` low after 2 edges.
- **Tie and alternation:** both valid from reset.
  - req0: AND 0xC0000000 & 0xC000001F.
  - req1: SLL 0xC00000FF by 3.
  - Required: req0 served first (0xC0000000) on `rsp0`, then req1 (0x000007F8) on `rsp1`.
  - Continuing both valid → grants 0,1,0,1.
- **Back-pressure:** req1 SRA 0xC00000FF by 3 with `rsp1_ready`=0 for 5 cycles while req0 is valid → `rsp_data` stays 0xF800001F, `req0_ready` stays 0; req0 is accepted the cycle after return to IDLE.
- **SUB with ovf check:** req0 0xFF0000FF − 0x71E0003E sel=100 → `rsp_data`=0x8D2000C1, `rsp_ovf`=0. Then 0x7FFFFFFF + 0x00000001 sel=010 → 0x80000000, `rsp_ovf`=1.
- **Wrong-owner ready:** in RESP owned by 0, pulse `rsp1_ready`=1 → no state change, `rsp1_valid` stays 0.
